mod_share_arbiter: RTL and testbench

Round-robin arbiter that time-shares one two-operand `mod` datapath instance among NUM_REQ requesters. It accepts one request at a time, drives the captured operands onto the unit's in0/in1 and waits UNIT_LATENCY cycles. It then returns the unit's out value to the winning requester, tagged with its index. It sits between requesting engines and a single `mod` instance, replacing per-requester copies of the unit.

---
 rtl/mod_share_arbiter.sv | 121 ++++++++++++
 tb/tb_mod_share_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_share_arbiter.sv
// Round-robin arbiter that time-shares a single multi-cycle `mod` unit among NUM_REQ requesters.
// One operation is in flight at a time; its result is returned to the winner along with the winner's index.
module mod_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 8,
    parameter int UNIT_LATENCY = 2,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in0,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in1,
    output logic [INPUT_WIDTH-1:0]         unit_in0,
    output logic [INPUT_WIDTH-1:0]         unit_in1,
    input  logic [OUTPUT_WIDTH-1:0]        unit_out,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [OUTPUT_WIDTH-1:0]        rsp_data,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           busy
);

    localparam int CNT_W = (UNIT_LATENCY > 0) ? $clog2(UNIT_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, RESP} state_t;

    state_t           state, state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  offset;
    logic [ID_W:0]    wsum;
    logic [NUM_REQ-1:0] rotated;
    logic             found;
    logic             handshake;
    logic [CNT_W-1:0] cnt;

    // Rotate requests so the pointer sits at bit 0; the lowest set bit is the winner's distance from it.
    always_comb begin
        rotated = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        found   = 1'b0;
        offset  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = ID_W'(k);
            end
        end
        wsum = {1'b0, rr_ptr} + {1'b0, offset};
        if (wsum >= (ID_W + 1)'(NUM_REQ)) begin
            wsum = wsum - (ID_W + 1)'(NUM_REQ);
        end
        winner   = wsum[ID_W-1:0];
        ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    end

    // Gating with reset keeps the grant low while reset is held, even if requests are asserted.
    assign handshake = reset && (state == IDLE) && found;
    assign busy      = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[rsp_id] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = (UNIT_LATENCY > 0) ? WAIT : CAPTURE;
            WAIT:    if (cnt == CNT_W'(1)) state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands stay on the unit until the next grant; the result and owner id are held until overwritten.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            unit_in0 <= '0;
            unit_in1 <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (handshake) begin
                unit_in0 <= req_in0[winner*INPUT_WIDTH +: INPUT_WIDTH];
                unit_in1 <= req_in1[winner*INPUT_WIDTH +: INPUT_WIDTH];
                rsp_id   <= winner;
                rr_ptr   <= ptr_next;
                cnt      <= CNT_W'(UNIT_LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == CAPTURE) begin
                rsp_data <= unit_out;
            end
        end
    end

endmodule

// File: tb/tb_mod_share_arbiter.sv
// Drives two arbiters (unit latency 2 with an adder, latency 0 with an XOR) from shared random stimulus;
// a queue-based scoreboard checks every response against a cycle-level reference model.
module tb_mod_share_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_in0;
    logic [31:0] req_in1;

    logic [3:0]  req_ready_v [2];
    logic [7:0]  unit_in0_v  [2];
    logic [7:0]  unit_in1_v  [2];
    logic [3:0]  rsp_valid_v [2];
    logic [7:0]  rsp_data_v  [2];
    logic [1:0]  rsp_id_v    [2];
    logic        busy_v      [2];
    logic [7:0]  unit_out_a;
    logic [7:0]  unit_out_b;
    logic [7:0]  pipe1;
    logic [7:0]  pipe2;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   started = 0;
    int   free_at [2];
    int   ptr [2];
    logic [7:0] exp_u0 [2];
    logic [7:0] exp_u1 [2];

    mod_share_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(8), .UNIT_LATENCY(2)) dut_a (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_v[0]),
        .req_in0(req_in0), .req_in1(req_in1), .unit_in0(unit_in0_v[0]), .unit_in1(unit_in1_v[0]),
        .unit_out(unit_out_a), .rsp_valid(rsp_valid_v[0]), .rsp_data(rsp_data_v[0]),
        .rsp_id(rsp_id_v[0]), .busy(busy_v[0])
    );

    mod_share_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(8), .UNIT_LATENCY(0)) dut_b (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_v[1]),
        .req_in0(req_in0), .req_in1(req_in1), .unit_in0(unit_in0_v[1]), .unit_in1(unit_in1_v[1]),
        .unit_out(unit_out_b), .rsp_valid(rsp_valid_v[1]), .rsp_data(rsp_data_v[1]),
        .rsp_id(rsp_id_v[1]), .busy(busy_v[1])
    );

    // Unit models: a two-stage pipelined adder and a purely combinational XOR.
    always @(posedge clock) begin
        pipe1 <= unit_in0_v[0] + unit_in1_v[0];
        pipe2 <= pipe1;
    end
    assign unit_out_a = pipe2;
    assign unit_out_b = unit_in0_v[1] ^ unit_in1_v[1];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [7:0] unit_fn(input int d, input logic [7:0] a, input logic [7:0] b);
        return (d == 0) ? 8'(a + b) : (a ^ b);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model for one arbiter: picks a winner from the pointer while the arbiter is free, and predicts grant, busy and operands.
    task automatic model_cycle(input int d);
        logic [3:0] exp_rdy;
        int         w;
        exp_t       e;
        exp_rdy = 4'b0000;
        w = -1;
        if (cyc >= free_at[d]) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req_valid[(ptr[d] + k) % 4]) w = (ptr[d] + k) % 4;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        check_output($sformatf("u%0d req_ready", d), 32'(req_ready_v[d]), 32'(exp_rdy));
        check_output($sformatf("u%0d busy", d), 32'(busy_v[d]), 32'(cyc < free_at[d]));
        check_output($sformatf("u%0d unit_in0", d), 32'(unit_in0_v[d]), 32'(exp_u0[d]));
        check_output($sformatf("u%0d unit_in1", d), 32'(unit_in1_v[d]), 32'(exp_u1[d]));
        if (w >= 0) begin
            exp_u0[d] = req_in0[w*8 +: 8];
            exp_u1[d] = req_in1[w*8 +: 8];
            e.id   = w;
            e.data = unit_fn(d, exp_u0[d], exp_u1[d]);
            e.due  = cyc + 2 + lat_of(d);
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
            ptr[d]     = (w + 1) % 4;
            free_at[d] = cyc + lat_of(d) + 3;
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        req_valid = v;
        req_in0   = a;
        req_in1   = b;
        #1;
        for (int d = 0; d < 2; d++) model_cycle(d);
    endtask

    // Assert reset mid-cycle, check that outputs clear at once with requests still asserted, then release.
    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset     = 1'b0;
        req_valid = 4'b1010;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_output($sformatf("u%0d reset req_ready", d), 32'(req_ready_v[d]), 32'h0);
            check_output($sformatf("u%0d reset busy", d), 32'(busy_v[d]), 32'h0);
            check_output($sformatf("u%0d reset unit_in0", d), 32'(unit_in0_v[d]), 32'h0);
            check_output($sformatf("u%0d reset rsp_valid", d), 32'(rsp_valid_v[d]), 32'h0);
            check_output($sformatf("u%0d reset rsp_data", d), 32'(rsp_data_v[d]), 32'h0);
            check_output($sformatf("u%0d reset rsp_id", d), 32'(rsp_id_v[d]), 32'h0);
            free_at[d] = 0;
            ptr[d]     = 0;
            exp_u0[d]  = 8'h00;
            exp_u1[d]  = 8'h00;
        end
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clock);
        #2;
        req_valid = 4'b0000;
        reset     = 1'b1;
        started   = 1'b1;
    endtask

    // Response monitor: every strobe must match the oldest outstanding expectation, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (started && reset) begin
                for (int d = 0; d < 2; d++) begin
                    if (rsp_valid_v[d] != 4'b0000) begin
                        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                            total++;
                            bad++;
                            $display("[TB] FAIL u%0d unexpected rsp actual rsp_valid=%0h required=none (cycle %0d)",
                                     d, rsp_valid_v[d], cyc);
                        end else begin
                            e = (d == 0) ? q0.pop_front() : q1.pop_front();
                            check_output($sformatf("u%0d rsp_valid", d), 32'(rsp_valid_v[d]), 32'(4'b0001 << e.id));
                            check_output($sformatf("u%0d rsp_id", d), 32'(rsp_id_v[d]), 32'(e.id));
                            check_output($sformatf("u%0d rsp_data", d), 32'(rsp_data_v[d]), 32'(e.data));
                            check_output($sformatf("u%0d rsp_cycle", d), 32'(cyc), 32'(e.due));
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_in0   = 32'h0;
        req_in1   = 32'h0;
        for (int d = 0; d < 2; d++) begin
            free_at[d] = 0;
            ptr[d]     = 0;
            exp_u0[d]  = 8'h00;
            exp_u1[d]  = 8'h00;
        end
        apply_reset();

        // Single requester 2 with known operands.
        apply_stimulus(4'b0100, 32'h0012_0000, 32'h0034_0000);
        repeat (6) apply_stimulus(4'b0000, 32'h0, 32'h0);

        // All requesters held high from reset: strict rotation.
        apply_reset();
        repeat (22) apply_stimulus(4'b1111, 32'h4433_2211, 32'h8877_6655);

        // Pointer wrap after granting requester 3.
        apply_reset();
        apply_stimulus(4'b1000, 32'h5500_0000, 32'h0A00_0000);
        repeat (5) apply_stimulus(4'b0000, 32'h0, 32'h0);
        repeat (6) apply_stimulus(4'b1001, 32'h0300_0007, 32'h0900_0011);

        // Operands F0/0F on requester 0.
        apply_reset();
        apply_stimulus(4'b0001, 32'h0000_00F0, 32'h0000_000F);
        repeat (6) apply_stimulus(4'b0000, 32'h0, 32'h0);

        // Reset during the second wait cycle, then requesters 1 and 3 compete.
        apply_stimulus(4'b0001, 32'h0000_0021, 32'h0000_0042);
        apply_stimulus(4'b0000, 32'h0, 32'h0);
        apply_reset();
        apply_stimulus(4'b1010, 32'h7700_6600, 32'h0100_0200);
        repeat (6) apply_stimulus(4'b0000, 32'h0, 32'h0);

        // Requester 1 pulses only while the arbiters are busy.
        apply_stimulus(4'b0001, 32'h0000_0005, 32'h0000_0006);
        apply_stimulus(4'b0010, 32'h0000_1100, 32'h0000_2200);
        repeat (6) apply_stimulus(4'b0000, 32'h0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            apply_stimulus(4'($urandom_range(0, 15)), $urandom(), $urandom());
        end
        repeat (8) apply_stimulus(4'b0000, 32'h0, 32'h0);

        check_output("u0 pending responses", 32'(q0.size()), 32'h0);
        check_output("u1 pending responses", 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
